// File: rtl/demux_32bit_reg.sv
// demux_32bit_reg: registered 1-to-2 demux with a one-entry buffer per lane.
// Define DEMUX_COUNT_EN to add per-lane output transfer counters cnt1/cnt2.
module demux_32bit_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp,
  input  logic             select,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_t;

  lane_t            st1_q, st1_d;
  lane_t            st2_q, st2_d;
  logic [WIDTH-1:0] d1_q, d2_q;
  logic             drain1, drain2;
  logic             room1, room2;
  logic             acc, wr1, wr2;

  assign out1_valid = (st1_q == FULL);
  assign out2_valid = (st2_q == FULL);
  assign out1       = d1_q;
  assign out2       = d2_q;

  assign drain1 = out1_valid & out1_ready;
  assign drain2 = out2_valid & out2_ready;

  // A full lane can take a new word in the same cycle it drains.
  assign room1 = !out1_valid | drain1;
  assign room2 = !out2_valid | drain2;

  assign in_ready = !reset & (select ? room2 : room1);

  assign acc = in_valid & in_ready;
  assign wr1 = acc & !select;
  assign wr2 = acc & select;

  always_comb begin
    st1_d = st1_q;
    unique case (st1_q)
      EMPTY: if (wr1) st1_d = FULL;
      FULL:  if (drain1 && !wr1) st1_d = EMPTY;
    endcase
  end

  always_comb begin
    st2_d = st2_q;
    unique case (st2_q)
      EMPTY: if (wr2) st2_d = FULL;
      FULL:  if (drain2 && !wr2) st2_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st1_q <= EMPTY;
      st2_q <= EMPTY;
      d1_q  <= '0;
      d2_q  <= '0;
    end else begin
      st1_q <= st1_d;
      st2_q <= st2_d;
      if (wr1) d1_q <= inp;
      if (wr2) d2_q <= inp;
    end
  end

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (drain1) cnt1 <= cnt1 + 16'd1;
      if (drain2) cnt2 <= cnt2 + 16'd1;
    end
  end
`endif

endmodule
